// File: rtl/p_to_s_pkg.sv
// p_to_s shared types and constants.
// Word width default, counter width helper, FSM states.
package p_to_s_pkg;

  localparam int DW_DEF = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cw_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/p_to_s_hold.sv
// p_to_s_hold: single-entry pending-word register.
// Owns the registered upstream ready (ready = not full).
module p_to_s_hold
  import p_to_s_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          ready_o
);

  logic          r_full;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic          w_full_nxt;

  assign w_full_nxt = wr_en | (r_full & ~rd_en);

  assign rd_data = r_data;
  assign full    = r_full;
  assign ready_o = r_ready;

  // Track occupancy; ready follows the next-cycle occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= ~w_full_nxt;
      if (wr_en) r_data <= wr_data;
    end
  end

endmodule

// File: rtl/p_to_s.sv
// p_to_s: parallel-to-serial converter, LSB first.
// One word shifting plus one pending word for bubble-free streaming.
module p_to_s
  import p_to_s_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic          data_o,
  output logic          last_o,
  input  logic          ready_i
);

  localparam int CW = cw_f(DW);

  state_t        r_state;
  logic [DW-1:0] r_sh;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_data;
  logic          r_last;

  logic          w_acc;
  logic          w_xfer;
  logic          w_fin;
  logic          w_wr;
  logic          w_rd;
  logic          w_full;
  logic          w_ld;
  logic [DW-1:0] w_pend;
  logic [DW-1:0] w_ld_word;
  logic [DW-1:0] w_sh_nxt;

  assign w_acc  = valid_i & ready_o;
  assign w_xfer = r_valid & ready_i;
  assign w_fin  = w_xfer & r_last;

  assign w_wr = w_acc & (r_state == SHIFT) & ~w_fin;
  assign w_rd = w_fin & w_full;

  assign w_ld = ((r_state == EMPTY) & w_acc) |
                (w_fin & (w_full | w_acc));

  assign w_ld_word = w_full ? w_pend : data_i;
  assign w_sh_nxt  = r_sh >> 1;

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign last_o  = r_last;

  p_to_s_hold #(
    .DW(DW)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (w_wr),
    .wr_data(data_i),
    .rd_en  (w_rd),
    .rd_data(w_pend),
    .full   (w_full),
    .ready_o(ready_o)
  );

  // Load / shift / drain state machine with registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_ld) begin
            r_state <= SHIFT;
            r_sh    <= w_ld_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_data  <= w_ld_word[0];
            r_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_ld) begin
            r_sh    <= w_ld_word;
            r_cnt   <= '0;
            r_data  <= w_ld_word[0];
            r_last  <= 1'b0;
          end else if (w_fin) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_xfer) begin
            r_sh    <= w_sh_nxt;
            r_cnt   <= r_cnt + 1'b1;
            r_data  <= w_sh_nxt[0];
            r_last  <= (r_cnt == CW'(DW - 2));
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p_to_s.sv
// tb_p_to_s: directed scenarios plus a queue-based stream scoreboard.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_p_to_s;
  import p_to_s_pkg::*;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_i = 1'b1;
  logic          ready_o;
  logic          valid_o;
  logic          data_o;
  logic          last_o;

  int errors = 0;
  int checks = 0;

  p_to_s #(
    .DW(DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .last_o (last_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  // Reference model: words accepted but not yet fully sent, front first.
  logic [DW-1:0] q[$];
  int            bidx = 0;
  bit            mon_en = 0;
  bit            rst_seen = 0;
  logic [DW-1:0] rx_sh = '0;
  int            n_acc = 0;
  int            n_rx = 0;
  int            n_drop = 0;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    logic          exp_v;
    logic          exp_r;
    if (rst) begin
      if (mon_en) n_drop += q.size();
      q.delete();
      bidx = 0;
      mon_en = 1;
      rst_seen = 1;
    end else if (mon_en) begin
      exp_v = (q.size() > 0);
      exp_r = rst_seen ? 1'b0 : (q.size() < 2);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, valid_o, exp_v);
      end
      checks++;
      if (ready_o !== exp_r) begin
        errors++;
        $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, ready_o, exp_r);
      end
      if (q.size() > 0) begin
        w = q[0];
        checks++;
        if (data_o !== w[bidx]) begin
          errors++;
          $display("FAIL mon_bit t=%0t got=%b exp=%b", $time, data_o, w[bidx]);
        end
        checks++;
        if (last_o !== (bidx == DW - 1)) begin
          errors++;
          $display("FAIL mon_last t=%0t got=%b exp=%b", $time, last_o, bidx == DW - 1);
        end
      end else begin
        checks++;
        if (last_o !== 1'b0) begin
          errors++;
          $display("FAIL mon_last_idle t=%0t got=%b exp=0", $time, last_o);
        end
      end
      if (valid_o && ready_i && q.size() > 0) begin
        rx_sh[bidx] = data_o;
        bidx++;
        if (bidx == DW) begin
          w = q.pop_front();
          checks++;
          if (rx_sh !== w) begin
            errors++;
            $display("FAIL loopback t=%0t got=%h exp=%h", $time, rx_sh, w);
          end
          bidx = 0;
          n_rx++;
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(data_i);
        n_acc++;
      end
      rst_seen = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({valid_o, data_o, last_o, ready_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0000", {valid_o, data_o, last_o, ready_o});
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_hold got=%b exp=0", ready_o);
    end
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got=%b%b exp=10", ready_o, valid_o);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    w = 6'h2D;
    step();
    valid_i = 1'b1;
    data_i = w;
    step();
    valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== (k < 6)) begin
        errors++;
        $display("FAIL single_valid k=%0d got=%b exp=%b", k, valid_o, k < 6);
      end
      if (k < 6) begin
        checks++;
        if (data_o !== w[k] || last_o !== (k == 5)) begin
          errors++;
          $display("FAIL single_bit k=%0d got=%b%b exp=%b%b",
                   k, data_o, last_o, w[k], k == 5);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] s;
    s = {6'h12, 6'h2D};
    step();
    valid_i = 1'b1;
    data_i = 6'h2D;
    step();
    data_i = 6'h12;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== (k < 12)) begin
        errors++;
        $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, valid_o, k < 12);
      end
      if (k < 12) begin
        checks++;
        if (data_o !== s[k] || last_o !== (k == 5 || k == 11)) begin
          errors++;
          $display("FAIL b2b_bit k=%0d got=%b%b exp=%b%b",
                   k, data_o, last_o, s[k], k == 5 || k == 11);
        end
      end
      step();
      if (k == 0) valid_i = 1'b0;
    end
  endtask

  task automatic test_stall();
    int   nx;
    logic pv, pr, pd, pl;
    nx = 0;
    pv = 0;
    pr = 0;
    pd = 0;
    pl = 0;
    step();
    valid_i = 1'b1;
    data_i = 6'h3F;
    step();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (valid_o && pv && !pr) begin
        checks++;
        if (data_o !== pd || last_o !== pl) begin
          errors++;
          $display("FAIL stall_hold c=%0d got=%b%b exp=%b%b", c, data_o, last_o, pd, pl);
        end
      end
      if (valid_o && ready_i) begin
        nx++;
        checks++;
        if (last_o !== (nx == 6)) begin
          errors++;
          $display("FAIL stall_last xfer=%0d got=%b exp=%b", nx, last_o, nx == 6);
        end
      end
      pv = valid_o;
      pr = ready_i;
      pd = data_o;
      pl = last_o;
      step();
      ready_i = ((c + 1) % 3 == 0);
    end
    ready_i = 1'b1;
    checks++;
    if (nx != 6 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_count got=%0d exp=6 valid=%b", nx, valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0]   w[3];
    logic [3*DW-1:0] got;
    logic [3*DW-1:0] exp;
    int              idx, nb;
    bit              tk, done;
    for (int i = 0; i < 3; i++) w[i] = DW'($urandom);
    idx = 0;
    nb = 0;
    got = '0;
    done = 0;
    step();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = w[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tk = valid_i && ready_o;
      step();
      if (tk) idx++;
      if (idx < 3) data_i = w[idx];
      else valid_i = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || idx != 2 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_stalled got rdy=%b idx=%0d vld=%b exp rdy=0 idx=2 vld=1",
               ready_o, idx, valid_o);
    end
    step();
    ready_i = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      tk = valid_i && ready_o;
      if (tk && idx == 2) begin
        checks++;
        if (nb < 6) begin
          errors++;
          $display("FAIL bp_third_early bits=%0d exp>=6", nb);
        end
      end
      if (valid_o && ready_i && nb < 3 * DW) begin
        got[nb] = data_o;
        nb++;
      end
      if (idx == 3 && !valid_o && nb == 3 * DW) done = 1;
      step();
      if (tk) idx++;
      if (idx < 3) data_i = w[idx];
      else valid_i = 1'b0;
    end
    valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_timeout bits=%0d idx=%0d exp bits=18 idx=3", nb, idx);
    end
    exp = {w[2], w[1], w[0]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_order got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    w = 6'h15;
    ready_i = 1'b1;
    step();
    valid_i = 1'b1;
    data_i = 6'h2A;
    step();
    data_i = DW'($urandom);
    step();
    valid_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending got rdy=%b vld=%b exp rdy=0 vld=1", ready_o, valid_o);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid_o, ready_o, last_o, data_o} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=0000", {valid_o, ready_o, last_o, data_o});
    end
    step();
    valid_i = 1'b1;
    data_i = w;
    step();
    valid_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== (k < 6) || (k < 6 && data_o !== w[k])) begin
        errors++;
        $display("FAIL mid_after k=%0d got=%b%b exp=%b%b",
                 k, valid_o, data_o, k < 6, (k < 6) ? w[k] : 1'b0);
      end
    end
  endtask

  task automatic test_random();
    bit drained;
    for (int c = 0; c < 600; c++) begin
      step();
      valid_i = 1'($urandom_range(0, 1));
      data_i = DW'($urandom);
      ready_i = (c < 300) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    end
    step();
    valid_i = 1'b0;
    ready_i = 1'b1;
    drained = 0;
    for (int c = 0; c < 40 && !drained; c++) begin
      @(negedge clk);
      if (!valid_o) drained = 1;
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL rand_drain_timeout valid=%b exp=0", valid_o);
    end
    checks++;
    if (n_rx + n_drop != n_acc || n_rx < 20) begin
      errors++;
      $display("FAIL rand_count got rx=%0d drop=%0d exp acc=%0d", n_rx, n_drop, n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p_to_s.md
Name: p_to_s

Overview:
- Parallel-to-serial converter; the stage directly upstream of the 6-bit serial-to-parallel deserializer.
- Accepts DW-bit words over a valid/ready handshake and emits them one bit per transfer, LSB first, on a valid/ready serial link.
- Holds one pending word behind the word being shifted, so back-to-back words stream with no bubble cycles.
- With DW=6, its serial output drives the deserializer's valid/data inputs, and the deserializer reassembles the original word.

Parameters:
- DW, 6, parallel word width in bits (legal range 2..32).
- CW, $clog2(DW), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid_i  input  1  upstream word valid.
- data_i  input  DW  upstream parallel word.
- ready_o  output  1  registered; block can accept a word this cycle.
- valid_o  output  1  registered; serial bit on data_o is valid.
- data_o  output  1  registered; current serial bit (LSB first).
- last_o  output  1  registered; data_o is bit DW-1 of the current word.
- ready_i  input  1  downstream accepts the serial bit this cycle.

Behaviour:
- Reset values at a clk edge with rst=1: valid_o=0, data_o=0, last_o=0, ready_o=0, pend_vld=0, cnt=0.
- First cycle after rst deasserts: ready_o=1.
- Word transfer (acc): valid_i && ready_o at a rising edge.
- Bit transfer (xfer): valid_o && ready_i at a rising edge.
- State EMPTY (valid_o=0): acc loads data_i into the shift register, sets cnt=0 and valid_o=1. data_o=data_i[0] on the next cycle, so word-to-first-bit latency is 1 cycle.
- State SHIFT (valid_o=1): on xfer with cnt<DW-1, shift right, data_o takes the next bit, and cnt increments.
- last_o=1 exactly when valid_o=1 and cnt=DW-1.
- Final xfer (cnt=DW-1), next word selected in this order:
  - pending word if pend_vld=1 (pend_vld clears);
  - else data_i if acc occurs in the same cycle;
  - else go to EMPTY with valid_o=0.
  - Loading a new word resets cnt=0 and keeps valid_o=1 with no gap.
- acc in SHIFT with no final xfer: the word goes into the pending register and pend_vld=1.
- ready_o next = !(pend_vld next); ready_o is a registered signal, not a combinational path from ready_i or valid_i.
- Stall: ready_i=0 holds data_o, last_o, cnt and the shift register unchanged. valid_o stays 1, so it never drops mid-word.
- With pend_vld=1, ready_o=0. An upstream valid_i held during this time must not be lost; it is taken once ready_o returns.
- valid_i=1 while ready_o=0 has no effect; data_i is sampled only on acc.
- rst mid-word discards the shift register and the pending word with no partial flush. The next word after reset starts at bit 0.
- Throughput: one bit per cycle while ready_i=1. Continuous words produce DW*N consecutive valid_o cycles.

Decomposition:
- Package p_to_s_pkg holds:
  - localparam DW_DEF=6;
  - a count-width function (clog2, minimum 1);
  - an enum state_t {EMPTY, SHIFT}.
- One sub-module is natural: p_to_s_hold, the single-entry pending-word register. It has ports wr_en, wr_data, rd_en, rd_data and full, and drives ready_o.
- The shift register, counter and FSM stay in the top level.

Test Plan:
- Single word 6'h2D, ready_i=1 -> valid_o high for 6 cycles starting 1 cycle after acc. data_o = 1,0,1,1,0,1, last_o only on the 6th bit, then valid_o=0.
- Back-to-back 6'h2D then 6'h12, valid_i held, ready_i=1 -> 12 consecutive valid_o cycles. Bits 1,0,1,1,0,1,0,1,0,0,1,0; last_o on cycles 6 and 12; no gap.
- 6'h3F loaded, ready_i toggling 1,0,0,1,... -> each bit is held stable while ready_i=0, exactly 6 xfers occur, and last_o coincides with the 6th xfer.
- ready_i=0 for 10 cycles while three words are offered -> 1st word in shift register, 2nd pending, ready_o=0. The 3rd word is not taken until the 1st word completes; order is preserved.
- rst=1 after the 3rd bit of 6'h2A with a pending word -> the next edge gives valid_o=0, ready_o=0, last_o=0. After release, word 6'h15 serializes as 1,0,1,0,1,0 from bit 0.
- Loopback into the 6-bit deserializer with random words, random valid_i and ready_i=1 -> every deserialized data_b equals the sent word, in order.
